// File: rtl/mpadder_pkg.sv
// Shared constants and state encoding for the mpadder arbiter slice.
package mpadder_pkg;

  localparam int MPADDER_W           = 1027;
  localparam int ARB_N_DEFAULT       = 3;
  localparam int ARB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

endpackage

// File: rtl/mpadder_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant of the first set request
// at or above the pointer, wrapping to bit 0.
module rr_grant #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_any
);

  logic [N-1:0] w_upperMask;
  logic [N-1:0] w_upperReq;
  logic [N-1:0] w_pickSrc;

  // Prefer requests at or above the pointer; fall back to the full vector
  // for the wrap-around, then isolate the lowest set bit.
  assign w_upperMask = ~((N'(1) << i_ptr) - N'(1));
  assign w_upperReq  = i_req & w_upperMask;
  assign w_pickSrc   = (|w_upperReq) ? w_upperReq : i_req;
  assign o_grant     = w_pickSrc & (~w_pickSrc + N'(1));
  assign o_any       = |i_req;

endmodule

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter sharing one mpadder between N requesters.
// Optional WAIT timeout is enabled with `define MPADDER_ARB_TIMEOUT_EN.
module mpadder_arbiter
  import mpadder_pkg::*;
#(
  parameter int N       = ARB_N_DEFAULT,
  parameter int W       = MPADDER_W,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_subtract,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W:0]     rsp_result,
  output logic           rsp_err,
  output logic           add_start,
  output logic           add_subtract,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W:0]     add_result,
  input  logic           add_done
);

  localparam int PW = $clog2(N);

  arbState_t     r_state;
  arbState_t     w_nextState;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [W-1:0]  r_opA;
  logic [W-1:0]  r_opB;
  logic          r_opSub;
  logic [W:0]    r_result;

  logic [N-1:0]  w_grant;
  logic          w_anyReq;
  logic [PW-1:0] w_grantIdx;
  logic [W-1:0]  w_selA;
  logic [W-1:0]  w_selB;
  logic          w_selSub;
  logic [PW-1:0] w_nextPtr;
  logic          w_rspAccept;
  logic          w_expire;

  rr_grant #(
    .N (N),
    .PW(PW)
  ) u_rrGrant (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_any  (w_anyReq)
  );

  // Operand mux keyed by the one-hot grant.
  always_comb begin
    w_grantIdx = '0;
    w_selA     = '0;
    w_selB     = '0;
    w_selSub   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_grantIdx = PW'(i);
        w_selA     = req_a[i*W +: W];
        w_selB     = req_b[i*W +: W];
        w_selSub   = req_subtract[i];
      end
    end
  end

  assign w_nextPtr   = (r_owner == PW'(N-1)) ? '0 : r_owner + PW'(1);
  assign w_rspAccept = rsp_ready[r_owner];

`ifdef MPADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign w_expire = (r_cnt == CW'(TIMEOUT - 1));
  assign rsp_err  = r_err;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT > 0);
  assign w_expire        = 1'b0;
  assign rsp_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (add_done || w_expire) w_nextState = RESP;
      RESP:    if (w_rspAccept) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A done coinciding with expiry takes the done branch, so err stays low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_opSub  <= 1'b0;
      r_result <= '0;
`ifdef MPADDER_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_opA   <= w_selA;
            r_opB   <= w_selB;
            r_opSub <= w_selSub;
            r_owner <= w_grantIdx;
          end
        end
        ISSUE: begin
`ifdef MPADDER_ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        WAIT: begin
          if (add_done) begin
            r_result <= add_result;
          end else if (w_expire) begin
            r_result <= '0;
`ifdef MPADDER_ARB_TIMEOUT_EN
            r_err    <= 1'b1;
`endif
          end else begin
`ifdef MPADDER_ARB_TIMEOUT_EN
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        RESP: begin
          if (w_rspAccept) begin
            r_ptr <= w_nextPtr;
`ifdef MPADDER_ARB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE) ? w_grant : '0;
  assign rsp_valid    = (r_state == RESP) ? (N'(1) << r_owner) : '0;
  assign rsp_result   = r_result;
  assign add_start    = (r_state == ISSUE);
  assign add_subtract = r_opSub;
  assign add_a        = r_opA;
  assign add_b        = r_opB;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Directed self-checking bench for mpadder_arbiter with a 2-cycle adder model.
// Exercises the timeout path when built with MPADDER_ARB_TIMEOUT_EN.
module tb_mpadder_arbiter;

  localparam int N = 3;
  localparam int W = 1027;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_subtract;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W:0]     rsp_result;
  logic           rsp_err;
  logic           add_start;
  logic           add_subtract;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_result;
  logic           add_done;

  logic           blockDone;
  logic           extraDone;
  logic           mP1, mP2;
  logic [W:0]     mRes1, mRes2;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mpadder_arbiter #(
    .N(N), .W(W), .TIMEOUT(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_subtract(req_subtract),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .add_start(add_start), .add_subtract(add_subtract), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done)
  );

  // Adder model: registers inputs every clock, done two cycles after start.
  always @(posedge clk) begin
    mP1   <= add_start;
    mP2   <= mP1;
    mRes1 <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
    mRes2 <= mRes1;
  end
  assign add_done   = (mP2 & ~blockDone) | extraDone;
  assign add_result = mRes2;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setOp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    req_a[idx*W +: W]   = a;
    req_b[idx*W +: W]   = b;
    req_subtract[idx]   = sub;
  endtask

  task automatic test_reset();
    logic [W:0] zr;
    zr = '0;
    resetn = 1'b0;
    cyc(2);
    nChecks++; if (req_ready !== 3'b000) begin nFail++; $display("[TB] FAIL reset_req_ready got=%b exp=000", req_ready); end
    nChecks++; if (rsp_valid !== 3'b000) begin nFail++; $display("[TB] FAIL reset_rsp_valid got=%b exp=000", rsp_valid); end
    nChecks++; if (rsp_result !== zr) begin nFail++; $display("[TB] FAIL reset_rsp_result low64 got=%h exp=0", rsp_result[63:0]); end
    nChecks++; if (rsp_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    nChecks++; if (add_start !== 1'b0) begin nFail++; $display("[TB] FAIL reset_add_start got=%b exp=0", add_start); end
    nChecks++; if ({add_subtract, add_a, add_b} !== {1'b0, {(2*W){1'b0}}}) begin
      nFail++; $display("[TB] FAIL reset_add_ops sub=%b a_low=%h b_low=%h exp=0", add_subtract, add_a[63:0], add_b[63:0]);
    end
    resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_add();
    logic [W:0] expR;
    expR = (W+1)'(12);
    setOp(0, W'(5), W'(7), 1'b0);
    req_valid = 3'b001;
    #1;
    nChecks++; if (req_ready !== 3'b001) begin nFail++; $display("[TB] FAIL add_grant got=%b exp=001", req_ready); end
    cyc(1);
    req_valid = 3'b000;
    nChecks++; if (add_start !== 1'b1) begin nFail++; $display("[TB] FAIL add_start_t1 got=%b exp=1", add_start); end
    nChecks++; if (req_ready !== 3'b000) begin nFail++; $display("[TB] FAIL add_ready_issue got=%b exp=000", req_ready); end
    nChecks++; if (add_a !== W'(5) || add_b !== W'(7)) begin
      nFail++; $display("[TB] FAIL add_operands a=%0h b=%0h exp a=5 b=7", add_a[63:0], add_b[63:0]);
    end
    cyc(1);
    nChecks++; if (add_start !== 1'b0) begin nFail++; $display("[TB] FAIL add_start_t2 got=%b exp=0", add_start); end
    cyc(1);
    nChecks++; if (rsp_valid !== 3'b000) begin nFail++; $display("[TB] FAIL add_rsp_early got=%b exp=000", rsp_valid); end
    cyc(1);
    nChecks++; if (rsp_valid !== 3'b001) begin nFail++; $display("[TB] FAIL add_rsp_valid_t4 got=%b exp=001", rsp_valid); end
    nChecks++; if (rsp_result !== expR) begin nFail++; $display("[TB] FAIL add_rsp_result low64 got=%h exp=%h", rsp_result[63:0], expR[63:0]); end
    nChecks++; if (rsp_err !== 1'b0) begin nFail++; $display("[TB] FAIL add_rsp_err got=%b exp=0", rsp_err); end
    rsp_ready = 3'b001;
    cyc(1);
    rsp_ready = 3'b000;
    nChecks++; if (rsp_valid !== 3'b000) begin nFail++; $display("[TB] FAIL add_rsp_released got=%b exp=000", rsp_valid); end
  endtask

  task automatic test_subtract_wrap();
    logic [W:0] expR;
    expR    = '1;
    expR[0] = 1'b0;
    setOp(0, W'(3), W'(5), 1'b1);
    req_valid = 3'b001;
    #1;
    nChecks++; if (req_ready !== 3'b001) begin nFail++; $display("[TB] FAIL sub_grant_wrap got=%b exp=001", req_ready); end
    cyc(1);
    req_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      nChecks++; if (add_subtract !== 1'b1) begin nFail++; $display("[TB] FAIL sub_held cycle=%0d got=%b exp=1", k, add_subtract); end
      cyc(1);
    end
    nChecks++; if (rsp_valid !== 3'b001) begin nFail++; $display("[TB] FAIL sub_rsp_valid got=%b exp=001", rsp_valid); end
    nChecks++; if (rsp_result !== expR) begin
      nFail++; $display("[TB] FAIL sub_rsp_result top=%b low64 got=%h exp top=%b low64=%h", rsp_result[W], rsp_result[63:0], expR[W], expR[63:0]);
    end
    rsp_ready = 3'b001;
    cyc(1);
    rsp_ready = 3'b000;
    nChecks++; if (add_subtract !== 1'b1) begin nFail++; $display("[TB] FAIL sub_retained_idle got=%b exp=1", add_subtract); end
  endtask

  task automatic test_contention();
    logic [N-1:0] order [4];
    logic [W:0]   expR  [4];
    int nGrants, nRsp, nStarts, budget;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    expR[0] = (W+1)'(17); expR[1] = (W+1)'(34); expR[2] = (W+1)'(51); expR[3] = (W+1)'(17);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) setOp(i, W'(16*(i+1)), W'(i+1), 1'b0);
    req_valid = 3'b111;
    rsp_ready = 3'b111;
    nGrants = 0; nRsp = 0; nStarts = 0; budget = 0;
    while (nRsp < 4 && budget < 60) begin
      #1;
      if (add_start === 1'b1) nStarts++;
      if (req_ready !== 3'b000 && nGrants < 4) begin
        nChecks++; if (req_ready !== order[nGrants]) begin nFail++; $display("[TB] FAIL rr_grant idx=%0d got=%b exp=%b", nGrants, req_ready, order[nGrants]); end
        nGrants++;
      end
      if (rsp_valid !== 3'b000) begin
        nChecks++; if (rsp_valid !== order[nRsp] || rsp_result !== expR[nRsp]) begin
          nFail++; $display("[TB] FAIL rr_rsp idx=%0d valid=%b low64=%h exp valid=%b low64=%h", nRsp, rsp_valid, rsp_result[63:0], order[nRsp], expR[nRsp][63:0]);
        end
        nRsp++;
      end
      if (nRsp < 4) begin
        cyc(1);
        budget++;
      end
    end
    req_valid = 3'b000;
    nChecks++; if (nRsp != 4) begin nFail++; $display("[TB] FAIL rr_timeout responses got=%0d exp=4", nRsp); end
    nChecks++; if (nStarts != 4) begin nFail++; $display("[TB] FAIL rr_start_count got=%0d exp=4", nStarts); end
    cyc(1);
    rsp_ready = 3'b000;
  endtask

  task automatic test_backpressure();
    logic [W:0] expR;
    int budget;
    expR = (W+1)'(123);
    setOp(2, W'(100), W'(23), 1'b0);
    req_valid = 3'b100;
    budget = 0;
    while (rsp_valid === 3'b000 && budget < 10) begin
      cyc(1);
      budget++;
    end
    nChecks++; if (rsp_valid !== 3'b100) begin nFail++; $display("[TB] FAIL bp_rsp_arrive got=%b exp=100", rsp_valid); end
    req_valid = 3'b011;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      nChecks++; if (rsp_valid !== 3'b100 || rsp_result !== expR) begin
        nFail++; $display("[TB] FAIL bp_hold cycle=%0d valid=%b low64=%h exp valid=100 low64=%h", k, rsp_valid, rsp_result[63:0], expR[63:0]);
      end
      nChecks++; if (req_ready !== 3'b000 || add_start !== 1'b0) begin
        nFail++; $display("[TB] FAIL bp_quiet cycle=%0d ready=%b start=%b exp ready=000 start=0", k, req_ready, add_start);
      end
    end
    rsp_ready = 3'b010;
    cyc(1);
    nChecks++; if (rsp_valid !== 3'b100) begin nFail++; $display("[TB] FAIL bp_foreign_ready got=%b exp=100", rsp_valid); end
    rsp_ready = 3'b100;
    cyc(1);
    rsp_ready = 3'b000;
    nChecks++; if (req_ready !== 3'b001) begin nFail++; $display("[TB] FAIL bp_next_grant got=%b exp=001", req_ready); end
    req_valid = 3'b000;
    cyc(1);
  endtask

  task automatic test_reset_mid_wait();
    logic [W:0] zr;
    logic sawRsp;
    zr = '0;
    blockDone = 1'b1;
    setOp(2, W'(77), W'(1), 1'b1);
    req_valid = 3'b100;
    cyc(1);
    req_valid = 3'b000;
    cyc(1);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    nChecks++; if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || add_start !== 1'b0) begin
      nFail++; $display("[TB] FAIL rst_wait_ctrl ready=%b valid=%b start=%b exp all 0", req_ready, rsp_valid, add_start);
    end
    nChecks++; if (rsp_result !== zr || rsp_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL rst_wait_rsp low64=%h err=%b exp 0", rsp_result[63:0], rsp_err);
    end
    nChecks++; if ({add_subtract, add_a, add_b} !== {1'b0, {(2*W){1'b0}}}) begin
      nFail++; $display("[TB] FAIL rst_wait_ops sub=%b a_low=%h b_low=%h exp=0", add_subtract, add_a[63:0], add_b[63:0]);
    end
    extraDone = 1'b1;
    cyc(1);
    extraDone = 1'b0;
    sawRsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid !== 3'b000) sawRsp = 1'b1;
      cyc(1);
    end
    nChecks++; if (sawRsp !== 1'b0) begin nFail++; $display("[TB] FAIL rst_late_done got=rsp exp=no rsp"); end
    req_valid = 3'b111;
    #1;
    nChecks++; if (req_ready !== 3'b001) begin nFail++; $display("[TB] FAIL rst_next_grant got=%b exp=001", req_ready); end
    req_valid = 3'b000;
    blockDone = 1'b0;
    cyc(1);
  endtask

`ifdef MPADDER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [W:0] zr;
    logic [W:0] expR;
    zr   = '0;
    expR = (W+1)'(42);
    blockDone = 1'b1;
    setOp(0, W'(20), W'(22), 1'b0);
    req_valid = 3'b001;
    cyc(1);
    req_valid = 3'b000;
    cyc(16);
    nChecks++; if (rsp_valid !== 3'b000) begin nFail++; $display("[TB] FAIL to_early got=%b exp=000", rsp_valid); end
    cyc(1);
    nChecks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b1) begin
      nFail++; $display("[TB] FAIL to_expire valid=%b err=%b exp valid=001 err=1", rsp_valid, rsp_err);
    end
    nChecks++; if (rsp_result !== zr) begin nFail++; $display("[TB] FAIL to_result low64 got=%h exp=0", rsp_result[63:0]); end
    rsp_ready = 3'b001;
    cyc(1);
    rsp_ready = 3'b000;
    nChecks++; if (rsp_err !== 1'b0) begin nFail++; $display("[TB] FAIL to_err_clear got=%b exp=0", rsp_err); end
    req_valid = 3'b001;
    cyc(1);
    req_valid = 3'b000;
    cyc(16);
    extraDone = 1'b1;
    cyc(1);
    extraDone = 1'b0;
    nChecks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL to_done_wins valid=%b err=%b exp valid=001 err=0", rsp_valid, rsp_err);
    end
    nChecks++; if (rsp_result !== expR) begin nFail++; $display("[TB] FAIL to_done_result low64 got=%h exp=%h", rsp_result[63:0], expR[63:0]); end
    rsp_ready = 3'b001;
    cyc(1);
    rsp_ready = 3'b000;
    blockDone = 1'b0;
  endtask
`else
  task automatic test_wait_forever();
    logic [W:0] expR;
    logic sawRsp;
    expR = (W+1)'(13);
    blockDone = 1'b1;
    setOp(0, W'(9), W'(4), 1'b0);
    req_valid = 3'b001;
    cyc(1);
    req_valid = 3'b000;
    sawRsp = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (rsp_valid !== 3'b000 || rsp_err !== 1'b0) sawRsp = 1'b1;
    end
    nChecks++; if (sawRsp !== 1'b0) begin nFail++; $display("[TB] FAIL wait_forever got=early rsp exp=none"); end
    extraDone = 1'b1;
    cyc(1);
    extraDone = 1'b0;
    nChecks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0) begin
      nFail++; $display("[TB] FAIL wait_done valid=%b err=%b exp valid=001 err=0", rsp_valid, rsp_err);
    end
    nChecks++; if (rsp_result !== expR) begin nFail++; $display("[TB] FAIL wait_result low64 got=%h exp=%h", rsp_result[63:0], expR[63:0]); end
    rsp_ready = 3'b001;
    cyc(1);
    rsp_ready = 3'b000;
    blockDone = 1'b0;
  endtask
`endif

  initial begin
    resetn       = 1'b0;
    req_valid    = '0;
    req_subtract = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = '0;
    blockDone    = 1'b0;
    extraDone    = 1'b0;
    test_reset();
    test_single_add();
    test_subtract_wrap();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
`ifdef MPADDER_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
